// File: rtl/crossbar_switch_rr.sv
// N_IN x N_OUT registered crossbar with per-output round-robin arbitration and per-input permission rows.
// Optional per-input deny counters are enabled by defining XBAR_DENY_CNT_EN.
module crossbar_switch_rr #(
  parameter int unsigned      N_IN     = 4,
  parameter int unsigned      N_OUT    = 4,
  parameter int unsigned      DATA_W   = 32,
  parameter logic [N_OUT-1:0] PERM_RST = '1,
  localparam int unsigned     DST_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int unsigned     SRC_W    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN-1:0]         in_valid,
  input  logic [N_IN*DST_W-1:0]   in_dest,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  output logic [N_IN-1:0]         in_ready,
  output logic [N_OUT-1:0]        out_valid,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT*SRC_W-1:0]  out_src,
  input  logic [N_OUT-1:0]        out_ready,
  input  logic                    perm_we,
  input  logic [SRC_W-1:0]        perm_idx,
  input  logic [N_OUT-1:0]        perm_mask,
  output logic [N_IN-1:0]         deny
`ifdef XBAR_DENY_CNT_EN
  ,
  input  logic                    deny_clr,
  output logic [N_IN*16-1:0]      deny_cnt
`endif
);

  logic [N_OUT-1:0]  perm      [N_IN];
  logic [SRC_W-1:0]  ptr       [N_OUT];
  logic [DATA_W-1:0] data_q    [N_OUT];
  logic [SRC_W-1:0]  src_q     [N_OUT];
  logic [DST_W-1:0]  dest      [N_IN];
  logic [N_IN-1:0]   permitted;
  logic [N_OUT-1:0]  win_vld;
  logic [SRC_W-1:0]  win_idx   [N_OUT];
  logic [DATA_W-1:0] win_data  [N_OUT];
  logic [N_OUT-1:0]  can_load;
  logic [N_IN-1:0]   grant;

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      dest[i]      = in_dest[i*DST_W +: DST_W];
      permitted[i] = (32'(dest[i]) < N_OUT) && perm[i][dest[i]];
    end
  end

  // Round-robin search from ptr[j], wrapping; the first matching requester wins.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      win_vld[j] = 1'b0;
      win_idx[j] = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
        idx = (32'(ptr[j]) + k) % N_IN;
        if (!win_vld[j] && in_valid[idx] && permitted[idx] && (32'(dest[idx]) == j)) begin
          win_vld[j] = 1'b1;
          win_idx[j] = SRC_W'(idx);
        end
      end
      win_data[j] = in_data[32'(win_idx[j])*DATA_W +: DATA_W];
      can_load[j] = !out_valid[j] || out_ready[j];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      grant[i] = 1'b0;
      if (in_valid[i] && permitted[i] && win_vld[dest[i]] &&
          (win_idx[dest[i]] == SRC_W'(i)) && can_load[dest[i]])
        grant[i] = 1'b1;
    end
    deny     = rst_n ? (in_valid & ~permitted) : '0;
    in_ready = rst_n ? (grant | (in_valid & ~permitted)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      for (int unsigned j = 0; j < N_OUT; j++) begin
        data_q[j] <= '0;
        src_q[j]  <= '0;
        ptr[j]    <= '0;
      end
      for (int unsigned i = 0; i < N_IN; i++)
        perm[i] <= PERM_RST;
    end else begin
      for (int unsigned j = 0; j < N_OUT; j++) begin
        if (win_vld[j] && can_load[j]) begin
          data_q[j]    <= win_data[j];
          src_q[j]     <= win_idx[j];
          out_valid[j] <= 1'b1;
          ptr[j]       <= SRC_W'((32'(win_idx[j]) + 32'd1) % N_IN);
        end else if (out_valid[j] && out_ready[j]) begin
          out_valid[j] <= 1'b0;
        end
      end
      if (perm_we && (32'(perm_idx) < N_IN))
        perm[perm_idx] <= perm_mask;
    end
  end

  always_comb begin
    out_data = '0;
    out_src  = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      out_data[j*DATA_W +: DATA_W] = data_q[j];
      out_src[j*SRC_W +: SRC_W]    = src_q[j];
    end
  end

`ifdef XBAR_DENY_CNT_EN
  logic [15:0] cnt_q [N_IN];

  // Clear takes priority over a same-cycle increment; counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else if (deny_clr) begin
      for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_IN; i++)
        if (deny[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  always_comb begin
    deny_cnt = '0;
    for (int unsigned i = 0; i < N_IN; i++) deny_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_crossbar_switch_rr.sv
// Scoreboard bench for crossbar_switch_rr: expected {src,data} queued per output at drive time, popped on output handshakes.
module tb_crossbar_switch_rr;
  localparam int NI = 4, NO = 4, DW = 32, DSTW = 2, SRCW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0]      in_valid, in_ready, deny;
  logic [NI*DSTW-1:0] in_dest;
  logic [NI*DW-1:0]   in_data;
  logic [NO-1:0]      out_valid, out_ready;
  logic [NO*DW-1:0]   out_data;
  logic [NO*SRCW-1:0] out_src;
  logic               perm_we;
  logic [SRCW-1:0]    perm_idx;
  logic [NO-1:0]      perm_mask;
`ifdef XBAR_DENY_CNT_EN
  logic               deny_clr;
  logic [NI*16-1:0]   deny_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [SRCW+DW-1:0] sb_q [NO][$];

  always #5 clk = ~clk;

  crossbar_switch_rr #(.N_IN(NI), .N_OUT(NO), .DATA_W(DW), .PERM_RST(4'b1111)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
    .perm_we(perm_we), .perm_idx(perm_idx), .perm_mask(perm_mask), .deny(deny)
`ifdef XBAR_DENY_CNT_EN
    , .deny_clr(deny_clr), .deny_cnt(deny_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int i, input int d, input logic [31:0] v);
    in_valid[i] = 1'b1;
    in_dest[i*DSTW +: DSTW] = DSTW'(d);
    in_data[i*DW +: DW] = v;
  endtask

  task automatic push(input int j, input int s, input logic [31:0] v);
    sb_q[j].push_back({SRCW'(s), v});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < NO; j++) begin
        if (out_valid[j] && out_ready[j]) begin
          if (sb_q[j].size() == 0)
            check($sformatf("unexpected_out%0d", j), 64'(out_valid[j]), 64'd0);
          else
            check($sformatf("sb_out%0d", j),
                  64'({out_src[j*SRCW +: SRCW], out_data[j*DW +: DW]}), 64'(sb_q[j].pop_front()));
        end
      end
    end
  end

  initial begin
    in_valid = '0; in_dest = '0; in_data = '0; out_ready = '1;
    perm_we = 1'b0; perm_idx = '0; perm_mask = '0;
`ifdef XBAR_DENY_CNT_EN
    deny_clr = 1'b0;
`endif
    // requests present while in reset must not be acknowledged
    set_in(0, 1, 32'h1111_1111);
    @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_deny", 64'(deny), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data[63:0]), 64'd0);
    in_valid = '0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // single path
    set_in(0, 2, 32'hA5A5_0001);
    push(2, 0, 32'hA5A5_0001);
    @(negedge clk);
    check("t2_ready", 64'(in_ready), 64'b0001);
    check("t2_deny", 64'(deny), 64'd0);
    next_cycle();
    in_valid = '0;
    @(negedge clk);
    check("t2_ovalid", 64'(out_valid[2]), 64'd1);
    check("t2_odata", 64'(out_data[2*DW +: DW]), 64'hA5A5_0001);
    check("t2_osrc", 64'(out_src[2*SRCW +: SRCW]), 64'd0);
    next_cycle();

    // fairness on output 1
    for (int i = 0; i < NI; i++) set_in(i, 1, 32'h3000_0000 + i);
    for (int k = 0; k < 6; k++) begin
      push(1, k % 4, 32'h3000_0000 + (k % 4));
      @(negedge clk);
      check($sformatf("t3_ready%0d", k), 64'(in_ready), 64'(1 << (k % 4)));
      next_cycle();
    end
    in_valid = '0;
    next_cycle();

    // backpressure on output 0
    out_ready[0] = 1'b0;
    set_in(1, 0, 32'hB0B0_0001);
    push(0, 1, 32'hB0B0_0001);
    @(negedge clk);
    check("t4_first_ready", 64'(in_ready), 64'b0010);
    next_cycle();
    in_valid = '0;
    set_in(2, 0, 32'hB0B0_0002);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_stall_ready", 64'(in_ready[2]), 64'd0);
      check("t4_hold_data", 64'(out_data[DW-1:0]), 64'hB0B0_0001);
      check("t4_hold_valid", 64'(out_valid[0]), 64'd1);
      next_cycle();
    end
    out_ready[0] = 1'b1;
    push(0, 2, 32'hB0B0_0002);
    @(negedge clk);
    check("t4_release_ready", 64'(in_ready[2]), 64'd1);
    next_cycle();
    in_valid = '0;
    @(negedge clk);
    check("t4_refill", 64'(out_data[DW-1:0]), 64'hB0B0_0002);
    next_cycle();

    // permission row write; same-cycle request sees the old row
    perm_we = 1'b1; perm_idx = 2'd1; perm_mask = 4'b1011;
    set_in(1, 2, 32'hC0C0_0001);
    push(2, 1, 32'hC0C0_0001);
    @(negedge clk);
    check("t5_old_row_ready", 64'(in_ready), 64'b0010);
    check("t5_old_row_deny", 64'(deny), 64'd0);
    next_cycle();
    perm_we = 1'b0;
    set_in(1, 2, 32'hC0C0_0002);
    @(negedge clk);
    check("t5_deny", 64'(deny), 64'b0010);
    check("t5_deny_ready", 64'(in_ready), 64'b0010);
    next_cycle();
    set_in(1, 3, 32'hC0C0_0003);
    push(3, 1, 32'hC0C0_0003);
    @(negedge clk);
    check("t5_out2_empty", 64'(out_valid[2]), 64'd0);
    check("t5_fwd_deny", 64'(deny), 64'd0);
    check("t5_fwd_ready", 64'(in_ready), 64'b0010);
    next_cycle();
    in_valid = '0;
    next_cycle();

`ifdef XBAR_DENY_CNT_EN
    check("t6_cnt1", 64'(deny_cnt[31:16]), 64'd1);
    perm_we = 1'b1; perm_idx = 2'd2; perm_mask = 4'b0000;
    next_cycle();
    perm_we = 1'b0;
    set_in(2, 1, 32'hDEAD_0002);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_deny", 64'(deny), 64'b0100);
      next_cycle();
    end
    in_valid = '0;
    @(negedge clk);
    check("t6_cnt3", 64'(deny_cnt[47:32]), 64'd3);
    next_cycle();
    set_in(2, 1, 32'hDEAD_0002);
    deny_clr = 1'b1;
    next_cycle();
    deny_clr = 1'b0;
    in_valid = '0;
    @(negedge clk);
    check("t6_clr", 64'(deny_cnt[47:32]), 64'd0);
    next_cycle();
    set_in(2, 1, 32'hDEAD_0002);
    for (int k = 0; k < 65540; k++) next_cycle();
    in_valid = '0;
    @(negedge clk);
    check("t6_sat", 64'(deny_cnt[47:32]), 64'hFFFF);
    check("t6_cnt0", 64'(deny_cnt[15:0]), 64'd0);
    next_cycle();
`endif

    // reset in the middle of traffic with outputs held
    for (int j = 0; j < NO; j++) check($sformatf("pre_rst_q%0d", j), 64'(sb_q[j].size()), 64'd0);
    out_ready = '0;
    set_in(0, 3, 32'hD0D0_0001);
    set_in(3, 1, 32'hD0D0_0003);
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("t1_valid", 64'(out_valid), 64'd0);
    check("t1_data_lo", 64'(out_data[63:0]), 64'd0);
    check("t1_data_hi", 64'(out_data[127:64]), 64'd0);
    check("t1_src", 64'(out_src), 64'd0);
    check("t1_ready", 64'(in_ready), 64'd0);
    check("t1_deny", 64'(deny), 64'd0);
    in_valid = '0;
    next_cycle();
    rst_n = 1'b1;
    out_ready = '1;
    next_cycle();

    // rows and pointers back at reset values
    set_in(1, 2, 32'hE0E0_0001);
    set_in(0, 1, 32'hE0E0_0000);
    set_in(2, 1, 32'hE0E0_0002);
    set_in(3, 1, 32'hE0E0_0003);
    push(2, 1, 32'hE0E0_0001);
    push(1, 0, 32'hE0E0_0000);
    @(negedge clk);
    check("post_rst_deny", 64'(deny), 64'd0);
    check("post_rst_ready", 64'(in_ready), 64'b0011);
    next_cycle();
    in_valid = '0;
    next_cycle();
    next_cycle();
    for (int j = 0; j < NO; j++) check($sformatf("end_q%0d", j), 64'(sb_q[j].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
